// File: rtl/cpu_defs.sv
// Shared definitions for the ten-bit pipelined CPU.
// Widths, special encodings and fetch-action codes.
package cpu_defs;

    localparam int ADDR_W  = 10;
    localparam int INSTR_W = 10;

    localparam logic [9:0] NOP  = 10'b0000000000;
    localparam logic [9:0] HALT = 10'b1111111111;

    typedef enum logic [1:0] {
        ACT_REDIRECT,
        ACT_HOLD,
        ACT_IDLE,
        ACT_FETCH
    } fetch_act_e;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: {pc, instruction, valid}.
// Bubble beats load; neither asserted holds the contents.
module if_id_register #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               bubble,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instruction,
    output logic               valid
);
    import cpu_defs::*;

    // Capture, squash or hold the slot; reset leaves a bubble
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc          <= '0;
            instruction <= INSTR_W'(NOP);
            valid       <= 1'b0;
        end else if (bubble) begin
            pc          <= '0;
            instruction <= INSTR_W'(NOP);
            valid       <= 1'b0;
        end else if (load) begin
            pc          <= pc_in;
            instruction <= instr_in;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, next-PC select, halt flag,
// saturating fetch counter and the IF/ID register.
module fetch_stage #(
    parameter int                ADDR_W   = 10,
    parameter int                INSTR_W  = 10,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  im_address,
    input  logic [INSTR_W-1:0] im_instruction,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [INSTR_W-1:0] if_id_instruction,
    output logic               if_id_valid,
    output logic               halted,
    output logic [15:0]        fetch_count
);
    import cpu_defs::*;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic              halted_next;
    logic              is_halt;
    logic              ifid_load;
    logic              ifid_bubble;
    fetch_act_e        act;

    assign im_address = pc;
    assign is_halt    = (im_instruction == INSTR_W'(HALT));

    // Pick this edge's action: redirect > hold > idle > fetch
    always_comb begin
        act = ACT_FETCH;
        if (branch_taken) act = ACT_REDIRECT;
        else if (stall)   act = ACT_HOLD;
        else if (halted)  act = ACT_IDLE;
    end

    // Next PC, next halt flag and IF/ID control per action
    always_comb begin
        pc_next     = pc;
        halted_next = halted;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        unique case (act)
            ACT_REDIRECT: begin
                pc_next     = branch_target;
                halted_next = 1'b0;
                ifid_bubble = 1'b1;
            end
            ACT_HOLD: begin
            end
            ACT_IDLE: begin
                ifid_bubble = 1'b1;
            end
            ACT_FETCH: begin
                ifid_load = 1'b1;
                if (is_halt) halted_next = 1'b1;
                else         pc_next     = pc + 1'b1;
            end
            default: begin
            end
        endcase
    end

    // PC and halt flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else begin
            pc     <= pc_next;
            halted <= halted_next;
        end
    end

    // Count valid captures into IF/ID, sticking at all-ones
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            fetch_count <= '0;
        else if (ifid_load && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
    end

    if_id_register #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clock       (clock),
        .reset       (reset),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .pc_in       (pc),
        .instr_in    (im_instruction),
        .pc          (if_id_pc),
        .instruction (if_id_instruction),
        .valid       (if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage.
// Expected IF/ID contents are queued before each edge.
module tb_fetch_stage;

    typedef struct {
        logic [9:0]  pc;
        logic [9:0]  instr;
        logic        valid;
        logic        halted;
        logic [15:0] count;
    } exp_t;

    localparam logic [9:0] T_HALT = 10'h3FF;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic [9:0]  im_address;
    logic [9:0]  im_instruction;
    logic [9:0]  if_id_pc;
    logic [9:0]  if_id_instruction;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [9:0]  mem [1024];

    int npass = 0;
    int ntotal = 0;

    exp_t q[$];

    logic [9:0]  m_pc;
    logic        m_halt;
    logic [15:0] m_count;
    exp_t        m_ifid;

    always #5 clock = ~clock;

    assign im_instruction = mem[im_address];

    fetch_stage dut (
        .clock             (clock),
        .reset             (reset),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .im_address        (im_address),
        .im_instruction    (im_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .if_id_valid       (if_id_valid),
        .halted            (halted),
        .fetch_count       (fetch_count)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        ntotal++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pc         = 10'd0;
        m_halt       = 1'b0;
        m_count      = 16'd0;
        m_ifid.pc    = 10'd0;
        m_ifid.instr = 10'd0;
        m_ifid.valid = 1'b0;
        q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " im_address"}, 32'(im_address), 32'd0);
        check({tag, " valid"}, 32'(if_id_valid), 32'd0);
        check({tag, " instr"}, 32'(if_id_instruction), 32'd0);
        check({tag, " pc"}, 32'(if_id_pc), 32'd0);
        check({tag, " halted"}, 32'(halted), 32'd0);
        check({tag, " count"}, 32'(fetch_count), 32'd0);
    endtask

    // Called just after a negedge; returns just after the next negedge
    task automatic step(input logic s, input logic b,
                        input logic [9:0] t);
        exp_t e;
        exp_t got;
        logic [9:0] ins;
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        #1;
        check("im_address", 32'(im_address), 32'(m_pc));
        ins = mem[m_pc];
        e   = m_ifid;
        if (b) begin
            e.pc = 10'd0; e.instr = 10'd0; e.valid = 1'b0;
            m_pc   = t;
            m_halt = 1'b0;
        end else if (s) begin
            e = m_ifid;
        end else if (m_halt) begin
            e.pc = 10'd0; e.instr = 10'd0; e.valid = 1'b0;
        end else begin
            e.pc = m_pc; e.instr = ins; e.valid = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            if (ins == T_HALT) m_halt = 1'b1;
            else m_pc = m_pc + 10'd1;
        end
        e.halted = m_halt;
        e.count  = m_count;
        q.push_back(e);
        @(posedge clock);
        #1;
        if (q.size() == 0) begin
            check("scoreboard empty", 32'd1, 32'd0);
        end else begin
            got = q.pop_front();
            check("if_id_valid", 32'(if_id_valid), 32'(got.valid));
            check("if_id_instr", 32'(if_id_instruction), 32'(got.instr));
            check("if_id_pc", 32'(if_id_pc), 32'(got.pc));
            check("halted", 32'(halted), 32'(got.halted));
            check("fetch_count", 32'(fetch_count), 32'(got.count));
            m_ifid = got;
        end
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 10'(i + 5);
            if (mem[i] == T_HALT) mem[i] = 10'd1;
        end
        reset         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 10'd0;
        model_reset();
        #1;
        check_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b0;

        // free run 0..3, then stall 3 cycles at PC=4
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 10'd0);
        check("pc at stall", 32'(im_address), 32'd4);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd0);
        check("stall held instr", 32'(if_id_instruction), 32'd8);
        check("stall held pc", 32'(if_id_pc), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0);

        // redirect to 100 at PC=7 while stalled
        check("pc before branch", 32'(im_address), 32'd7);
        step(1'b1, 1'b1, 10'd100);
        check("redirect pc", 32'(im_address), 32'd100);
        step(1'b0, 1'b0, 10'd0);
        check("target captured", 32'(if_id_pc), 32'd100);
        step(1'b0, 1'b0, 10'd0);

        // HALT at 6: stalled first, then captured, idle, then redirect
        mem[6] = T_HALT;
        step(1'b0, 1'b1, 10'd4);
        step(1'b0, 1'b0, 10'd0);
        step(1'b0, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd0);
        check("halt not in stall", 32'(halted), 32'd0);
        step(1'b0, 1'b0, 10'd0);
        check("halt pc", 32'(if_id_pc), 32'd6);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0);
        step(1'b1, 1'b0, 10'd0);
        check("frozen pc", 32'(im_address), 32'd6);
        step(1'b0, 1'b1, 10'd20);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0);
        mem[6] = 10'd11;

        // PC wrap 1022 -> 1023 -> 0 -> 1
        step(1'b0, 1'b1, 10'd1022);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 10'd0);
        check("wrap pc", 32'(im_address), 32'd3);

        // asynchronous reset in the middle of a stall
        step(1'b1, 1'b0, 10'd0);
        stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 10'd55;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async reset");
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
